// File: rtl/dkong_sprite_dma.sv
// Sprite attribute DMA: once per frame, requests the system bus from the Z80
// and copies XFER_LEN bytes from work RAM (SRC_BASE) into the sprite buffer
// (DST_BASE), one read/write pair per byte.
//
// Ports:
//   masterclk, rst         clock, synchronous active-high reset
//   start, enable          frame trigger pulse, DMA enable level
//   busrq / busak          bus request to CPU / bus grant from CPU
//   mem_addr, mem_rd,      bus address and strobes while granted
//   mem_wr, mem_wdata
//   mem_rdata, mem_wait    read data, memory stall (holds current strobe)
//   busy, done, aborted    status: active, release pulse, early-end flag
module dkong_sprite_dma #(
    parameter logic [15:0] SRC_BASE = 16'h6900,
    parameter logic [15:0] DST_BASE = 16'h7000,
    parameter int unsigned XFER_LEN = 384
) (
    input  logic        masterclk,
    input  logic        rst,
    input  logic        start,
    input  logic        enable,
    output logic        busrq,
    input  logic        busak,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  mem_wdata,
    input  logic        mem_wait,
    output logic        busy,
    output logic        done,
    output logic        aborted
);

    localparam int unsigned IDX_W = 12;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(XFER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_READ,
        S_WRITE,
        S_RELEASE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic             busrq_q, busrq_d;
    logic             mem_rd_q, mem_rd_d;
    logic             mem_wr_q, mem_wr_d;
    logic [15:0]      mem_addr_q, mem_addr_d;
    logic [7:0]       mem_wdata_q, mem_wdata_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;

    // State and output registers.
    always_ff @(posedge masterclk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            index_q     <= '0;
            busrq_q     <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            busrq_q     <= busrq_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    // Next state, then outputs decoded from the next state so every output
    // is a flop that reflects the state it is registered alongside.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        mem_wdata_d = mem_wdata_q;
        aborted_d   = aborted_q;

        unique case (state_q)
            S_IDLE: begin
                if (start && enable) begin
                    state_d   = S_REQ;
                    index_d   = '0;
                    aborted_d = 1'b0;
                end
            end
            S_REQ: begin
                if (busak) state_d = S_READ;
            end
            S_READ: begin
                if (!mem_wait) begin
                    mem_wdata_d = mem_rdata;
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                // Grant and enable are only examined once the byte is written.
                if (!mem_wait) begin
                    if (index_q == LAST_IDX) begin
                        state_d = S_RELEASE;
                    end else if (!enable || !busak) begin
                        aborted_d = 1'b1;
                        state_d   = S_RELEASE;
                    end else begin
                        index_d = index_q + 12'd1;
                        state_d = S_READ;
                    end
                end
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        busrq_d  = (state_d == S_REQ) || (state_d == S_READ) || (state_d == S_WRITE);
        mem_rd_d = (state_d == S_READ);
        mem_wr_d = (state_d == S_WRITE);
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_RELEASE);

        if (state_d == S_READ)
            mem_addr_d = SRC_BASE + 16'(index_d);
        else if (state_d == S_WRITE)
            mem_addr_d = DST_BASE + 16'(index_d);
        else
            mem_addr_d = mem_addr_q;
    end

    assign busrq     = busrq_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_dkong_sprite_dma.sv
// Testbench for dkong_sprite_dma. Four DUT instances cover the parameter
// sets (nominal 384 bytes, 4 bytes, 1 byte, 2 bytes from 0xFFFF). A shared
// memory model supplies read data as a function of address, stalls strobes
// by a programmable count, and answers busrq with busak one cycle later.
// Every completed bus access is logged and compared against a queue of
// expected accesses pushed when each transfer is started.
module tb_dkong_sprite_dma;

    localparam int NI = 4;
    localparam logic [15:0] DST = 16'h7000;

    function automatic logic [15:0] src_of(input int g);
        return (g == 3) ? 16'hFFFF : 16'h6900;
    endfunction

    function automatic int len_of(input int g);
        case (g)
            0:       return 384;
            1:       return 4;
            2:       return 1;
            default: return 2;
        endcase
    endfunction

    // Source byte for address a; gives byte i at 0x6900+i.
    function automatic logic [7:0] pat(input logic [15:0] a);
        return 8'(a - 16'h6900);
    endfunction

    typedef struct packed {
        logic        wr;
        logic [1:0]  g;
        logic [15:0] addr;
        logic [7:0]  data;
    } bus_ev_t;

    logic            clk;
    logic            rst;
    logic [NI-1:0]   start;
    logic [NI-1:0]   enable;
    logic [NI-1:0]   busrq;
    logic [NI-1:0]   busak;
    logic [15:0]     mem_addr  [NI];
    logic [NI-1:0]   mem_rd;
    logic [NI-1:0]   mem_wr;
    logic [7:0]      mem_rdata [NI];
    logic [7:0]      mem_wdata [NI];
    logic [NI-1:0]   mem_wait;
    logic [NI-1:0]   busy;
    logic [NI-1:0]   done;
    logic [NI-1:0]   aborted;

    logic [NI-1:0]   hold_low;
    int              rd_w [NI];
    int              wr_w [NI];
    logic [3:0]      rd_cnt [NI];
    logic [3:0]      wr_cnt [NI];

    int strobe_cnt [NI] = '{0, 0, 0, 0};
    int done_cnt   [NI] = '{0, 0, 0, 0};
    int ovl_cnt    [NI] = '{0, 0, 0, 0};

    bus_ev_t exp_q[$];
    bus_ev_t obs_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dkong_sprite_dma #(
            .SRC_BASE(src_of(g)),
            .DST_BASE(DST),
            .XFER_LEN(len_of(g))
        ) u_dut (
            .masterclk(clk),
            .rst      (rst),
            .start    (start[g]),
            .enable   (enable[g]),
            .busrq    (busrq[g]),
            .busak    (busak[g]),
            .mem_addr (mem_addr[g]),
            .mem_rd   (mem_rd[g]),
            .mem_wr   (mem_wr[g]),
            .mem_rdata(mem_rdata[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_wait (mem_wait[g]),
            .busy     (busy[g]),
            .done     (done[g]),
            .aborted  (aborted[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: stall the first rd_w/wr_w cycles of each strobe.
    always_comb begin
        for (int g = 0; g < NI; g++) begin
            mem_wait[g]  = (mem_rd[g] && (int'(rd_cnt[g]) < rd_w[g])) ||
                           (mem_wr[g] && (int'(wr_cnt[g]) < wr_w[g]));
            mem_rdata[g] = mem_wait[g] ? 8'hEE : pat(mem_addr[g]);
        end
    end

    always_ff @(posedge clk) begin
        for (int g = 0; g < NI; g++) begin
            rd_cnt[g] <= (mem_rd[g] && mem_wait[g]) ? rd_cnt[g] + 4'd1 : 4'd0;
            wr_cnt[g] <= (mem_wr[g] && mem_wait[g]) ? wr_cnt[g] + 4'd1 : 4'd0;
            busak[g]  <= busrq[g] & ~hold_low[g];
        end
    end

    // Bus monitor: logs completed accesses and counts strobe/done cycles.
    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (mem_rd[g] && !mem_wait[g])
                obs_q.push_back('{1'b0, 2'(g), mem_addr[g], mem_rdata[g]});
            if (mem_wr[g] && !mem_wait[g])
                obs_q.push_back('{1'b1, 2'(g), mem_addr[g], mem_wdata[g]});
            if (mem_rd[g] || mem_wr[g]) strobe_cnt[g] <= strobe_cnt[g] + 1;
            if (mem_rd[g] && mem_wr[g]) ovl_cnt[g] <= ovl_cnt[g] + 1;
            if (done[g]) done_cnt[g] <= done_cnt[g] + 1;
        end
    end

    task automatic check(input string nm, input longint act, input longint req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic push_exp(input int g, input int n);
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            a = src_of(g) + 16'(i);
            exp_q.push_back('{1'b0, 2'(g), a, pat(a)});
            exp_q.push_back('{1'b1, 2'(g), DST + 16'(i), pat(a)});
        end
    endtask

    task automatic drain(input string nm);
        bus_ev_t e, o;
        check({nm, " access count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check({nm, " access"}, o, e);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic pulse_start(input int g);
        @(negedge clk);
        start[g] = 1'b1;
        @(posedge clk);
        #1 start[g] = 1'b0;
    endtask

    // Returns k: number of edges after the start edge when done is first seen.
    task automatic wait_done(input int g, output int k, output bit ok);
        ok = 1'b0;
        k  = 0;
        while (!ok && k < 20000) begin
            @(negedge clk);
            if (done[g]) ok = 1'b1;
            else begin
                @(posedge clk);
                k++;
            end
        end
    endtask

    task automatic wait_bus(input int g, input bit wr, input logic [15:0] a, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000 && !ok; i++) begin
            @(negedge clk);
            if ((wr ? mem_wr[g] : mem_rd[g]) && mem_addr[g] == a) ok = 1'b1;
        end
    endtask

    typedef struct {
        int g;
        int rw;
        int ww;
        int cycles;   // edges from start edge through the end of the done cycle
        int strobes;  // cycles with mem_rd or mem_wr high
    } vec_t;

    initial begin
        vec_t vt[5];
        int   k;
        bit   ok;
        int   d0, s0;
        bit   bad;

        // cycles = 1 (busak delay) + 1 (REQ) + N*(rw+ww+2) + 1 (done cycle)
        vt[0] = '{0, 0, 0, 771, 768};
        vt[1] = '{1, 3, 2, 31, 28};
        vt[2] = '{1, 0, 0, 11, 8};
        vt[3] = '{2, 0, 0, 5, 2};
        vt[4] = '{3, 0, 0, 7, 4};

        rst      = 1'b1;
        start    = '0;
        enable   = '1;
        hold_low = '0;
        for (int g = 0; g < NI; g++) begin
            rd_w[g] = 0;
            wr_w[g] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset busrq",   busrq[0],     0);
        check("reset mem_rd",  mem_rd[0],    0);
        check("reset mem_wr",  mem_wr[0],    0);
        check("reset busy",    busy[0],      0);
        check("reset done",    done[0],      0);
        check("reset aborted", aborted[0],   0);
        check("reset addr",    mem_addr[0],  0);
        check("reset wdata",   mem_wdata[0], 0);
        @(negedge clk);
        rst = 1'b0;

        // start with enable low is ignored
        enable[2] = 1'b0;
        pulse_start(2);
        repeat (3) @(posedge clk);
        #1;
        check("disabled start busy",  busy[2],  0);
        check("disabled start busrq", busrq[2], 0);
        enable[2] = 1'b1;

        for (int v = 0; v < 5; v++) begin
            int g;
            g = vt[v].g;
            rd_w[g] = vt[v].rw;
            wr_w[g] = vt[v].ww;
            obs_q.delete();
            push_exp(g, len_of(g));
            pulse_start(g);
            d0 = done_cnt[g];
            s0 = strobe_cnt[g];
            wait_done(g, k, ok);
            check($sformatf("vec%0d done seen", v), ok, 1);
            check($sformatf("vec%0d latency", v), k + 1, vt[v].cycles);
            check($sformatf("vec%0d aborted", v), aborted[g], 0);
            check($sformatf("vec%0d busrq at done", v), busrq[g], 0);
            repeat (4) @(posedge clk);
            #1;
            check($sformatf("vec%0d busy after", v), busy[g], 0);
            check($sformatf("vec%0d done count", v), done_cnt[g] - d0, 1);
            check($sformatf("vec%0d strobe cycles", v), strobe_cnt[g] - s0, vt[v].strobes);
            drain($sformatf("vec%0d", v));
            rd_w[g] = 0;
            wr_w[g] = 0;
        end

        // Abort: drop enable during byte 10's READ
        push_exp(0, 11);
        pulse_start(0);
        wait_bus(0, 1'b0, 16'h6900 + 16'd10, ok);
        check("abort reached byte 10", ok, 1);
        enable[0] = 1'b0;
        wait_done(0, k, ok);
        check("abort done seen", ok, 1);
        check("abort aborted with done", aborted[0], 1);
        check("abort busrq dropped", busrq[0], 0);
        repeat (5) @(posedge clk);
        #1;
        check("abort aborted held", aborted[0], 1);
        drain("abort");
        enable[0] = 1'b1;

        // Grant delay, then a retrigger mid-transfer
        hold_low[0] = 1'b1;
        push_exp(0, 384);
        pulse_start(0);
        d0  = done_cnt[0];
        bad = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (mem_rd[0] || mem_wr[0] || !busrq[0]) bad = 1'b1;
        end
        check("grant wait no strobes", bad, 0);
        check("grant wait aborted cleared", aborted[0], 0);
        hold_low[0] = 1'b0;
        wait_bus(0, 1'b1, DST + 16'd20, ok);
        check("grant reached byte 20", ok, 1);
        pulse_start(0);
        wait_done(0, k, ok);
        check("grant done seen", ok, 1);
        check("grant aborted", aborted[0], 0);
        repeat (10) @(posedge clk);
        #1;
        check("grant single done", done_cnt[0] - d0, 1);
        drain("grant");

        // Reset during byte 100's WRITE, then restart from index 0
        pulse_start(0);
        wait_bus(0, 1'b1, DST + 16'd100, ok);
        check("reset reached byte 100", ok, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midreset busrq", busrq[0],  0);
        check("midreset mem_wr", mem_wr[0], 0);
        check("midreset busy",  busy[0],   0);
        check("midreset done",  done[0],   0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        exp_q.delete();
        obs_q.delete();
        push_exp(0, 384);
        pulse_start(0);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (mem_rd[0]) ok = 1'b1;
        end
        check("restart first read seen", ok, 1);
        check("restart first addr", mem_addr[0], 16'h6900);
        wait_done(0, k, ok);
        check("restart done seen", ok, 1);
        drain("restart");

        for (int g = 0; g < NI; g++)
            check($sformatf("inst%0d rd/wr overlap", g), ovl_cnt[g], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dkong_sprite_dma.md
Name: dkong_sprite_dma

Overview:
- Bus-mastering DMA controller that copies the sprite attribute table from CPU work RAM into the sprite-engine buffer once per frame.
- Uses a BUSREQ/BUSACK handshake with the Z80 core, so the CPU and DMA share the single system memory bus.
- Sits inside dkong_system between the CPU bus mux and the RAM/sprite-buffer decoders, clocked by masterclk.
- The frame trigger comes from the video timing (vblank start); the enable comes from the CPU-writable DMA-enable latch.

Parameters:
- SRC_BASE, 16'h6900, first source byte address in work RAM.
- DST_BASE, 16'h7000, first destination byte address in the sprite buffer.
- XFER_LEN, 384, bytes per transfer; legal range 1..4096.

Ports:
- masterclk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle trigger pulse (vblank start).
- enable  input  1  DMA enable latch; level.
- busrq  output  1  bus request to the CPU, active-high.
- busak  input  1  bus grant from the CPU, active-high.
- mem_addr  output  16  bus address while granted.
- mem_rd  output  1  read strobe.
- mem_wr  output  1  write strobe.
- mem_rdata  input  8  read data; valid in the cycle mem_wait is low during READ.
- mem_wdata  output  8  write data.
- mem_wait  input  1  memory stall; the current strobe is held while it is high.
- busy  output  1  high from REQ through RELEASE inclusive.
- done  output  1  one-cycle pulse when the bus is released.
- aborted  output  1  set with done if the transfer ended early; held until the next accepted start.

Behaviour:
- Reset (rst=1 at an edge): state IDLE. busrq, mem_rd, mem_wr, busy, done and aborted are 0. mem_addr=0, mem_wdata=0, index=0.
- Reset mid-transfer follows the same rule: strobes and busrq drop on the next edge.
- All outputs are registered.
- IDLE:
  - start=1 and enable=1: go to REQ, set busrq=1 and busy=1 next cycle, clear index and aborted.
  - start=1 with enable=0: ignored.
- REQ: hold busrq. When busak=1 is sampled, go to READ. No timeout; wait indefinitely.
- READ:
  - mem_addr = SRC_BASE + index (16-bit, wraps modulo 2^16), mem_rd=1.
  - Stay while mem_wait=1.
  - In the first cycle with mem_wait=0: latch mem_rdata into mem_wdata, then go to WRITE.
- WRITE:
  - mem_addr = DST_BASE + index (wraps), mem_wr=1, mem_wdata stable.
  - Stay while mem_wait=1.
  - On the completing cycle (mem_wait=0):
    - if index = XFER_LEN-1, go to RELEASE;
    - else if enable=0 or busak=0, set aborted=1 and go to RELEASE;
    - else increment index and go to READ.
- RELEASE: busrq=0, mem_rd=0, mem_wr=0, done=1 for exactly this cycle, busy=1. Next cycle: IDLE, busy=0.
- mem_rd and mem_wr are never high together. Both are 0 outside READ and WRITE.
- Throughput with zero wait: 2 cycles per byte.
  - Latency from start to done with busak already high: 1 (REQ) + 2×XFER_LEN + 1 (RELEASE) cycles after the start edge.
- start pulses while busy=1 are ignored; there is no queuing.
- busak dropping inside a READ or WRITE does not cut that byte short. It is checked only at WRITE completion.
- Index width is 12 bits. The final-byte compare uses XFER_LEN-1, so XFER_LEN=1 performs exactly one read/write pair.
- The source and destination ranges may overlap; bytes are copied in ascending order with no special handling.

Test Plan:
- Nominal:
  - Stimulus: XFER_LEN=384, busak tied to busrq with 1-cycle delay, mem_wait=0, source pattern byte=i[7:0].
  - Required: destination 0x7000+i holds i[7:0] for i=0..383; done pulses exactly once, 771 cycles after start; aborted=0.
- Wait states:
  - Stimulus: mem_wait high for 3 cycles on every read and 2 on every write, XFER_LEN=4.
  - Required: each strobe is held across its stalls, no duplicate or missed bytes, 28 cycles in READ/WRITE total.
- Abort:
  - Stimulus: enable deasserted during byte 10's READ.
  - Required: byte 10 is still written; done and aborted are 1 in the same cycle; bytes 11..383 are untouched; busrq drops.
- Grant delay and retrigger:
  - Stimulus: busak held low for 50 cycles; a second start is issued mid-transfer.
  - Required: no strobes occur before busak; the second start is ignored and exactly one done is produced.
- Reset mid-transfer:
  - Stimulus: rst at byte 100's WRITE.
  - Required: next edge has busrq=0, mem_wr=0, busy=0, done=0; a subsequent start restarts at index 0 (mem_addr=SRC_BASE).
- Edge cases:
  - Stimulus: XFER_LEN=1, and SRC_BASE=16'hFFFF with XFER_LEN=2.
  - Required: a single byte is copied for XFER_LEN=1; for the wrap case the source addresses are 0xFFFF then 0x0000.
